// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM states, frame width,
// serial line levels and the even-parity helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // Line levels for the idle line, the start bit and the stop bit
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Even parity: the parity bit makes the total number of ones even
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer (master) offers TX_DATA with TX_VALID; the transmitter
// (slave) takes it on any edge where TX_READY is also high.
interface uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] TX_DATA;
    logic                      TX_VALID;
    logic                      TX_READY;

    modport master (
        output TX_DATA,
        output TX_VALID,
        input  TX_READY
    );

    modport slave (
        input  TX_DATA,
        input  TX_VALID,
        output TX_READY
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO in front of the serialiser.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter. The read port is combinational so
// the transmitter can load the head byte on the same edge it pops.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = UART_DATA_BITS
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr_reg;
    logic [ADDR_W:0]   rd_ptr_reg;
    logic              wr_ok;
    logic              rd_ok;

    // Writes are refused when full and reads when empty, whatever the caller asks
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                     (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
    assign rd_data = mem[rd_ptr_reg[ADDR_W-1:0]];

    // Storage array; contents need no reset because the pointers gate them
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Read/write pointers; reset empties the FIFO
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes serialised as 8N1 frames on TXD,
// LSB first, CLKS_PER_BIT clock cycles per bit.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between data bit 7 and the stop bit (8E1). Undefined gives plain 8N1.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic      CLK,
    input  logic      RESET,
    uart_tx_if.slave  tx_bus,
    output logic      TXD,
    output logic      BUSY
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

    uart_state_t                state_reg, state_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    logic [BIT_W-1:0]           bit_reg, bit_next;
    logic [UART_DATA_BITS-1:0]  shift_reg, shift_next;
    logic                       txd_reg, txd_next;
`ifdef UART_TX_PARITY_EN
    logic                       parity_reg, parity_next;
`endif

    logic                       pop;
    logic                       bit_end;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [UART_DATA_BITS-1:0]  fifo_rd_data;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .wr_en   (tx_bus.TX_VALID),
        .wr_data (tx_bus.TX_DATA),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tx_bus.TX_READY = !fifo_full;
    assign TXD             = txd_reg;
    assign BUSY            = (state_reg != IDLE) || !fifo_empty;
    assign bit_end         = (cnt_reg == CNT_LAST);

    // State, counters, shift register and the registered line output
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            txd_reg    <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            txd_reg    <= txd_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // Next-state, bit timing, pop decision and the line level for the next cycle
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        txd_next    = LINE_IDLE;
        pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif

        // Bit-period counter free-runs while a frame is active and wraps at each boundary
        if (state_reg != IDLE) begin
            cnt_next = bit_end ? '0 : cnt_reg + CNT_W'(1);
        end

        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_reg == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        shift_next = shift_reg >> 1;
                        bit_next   = bit_reg + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next start bit when a byte is waiting
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Loading a new byte restarts all per-frame bookkeeping
        if (pop) begin
            shift_next  = fifo_rd_data;
            bit_next    = '0;
            cnt_next    = '0;
`ifdef UART_TX_PARITY_EN
            parity_next = even_parity(fifo_rd_data);
`endif
        end

        // Line level follows the state being entered so TXD is glitch-free and registered
        case (state_next)
            START:   txd_next = LINE_START;
            DATA:    txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_next = parity_next;
`endif
            STOP:    txd_next = LINE_STOP;
            default: txd_next = LINE_IDLE;
        endcase
    end

endmodule
